// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the vga_capture frame grabber.
package vga_capture_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_VS,
      CAPTURE,
      DRAIN
   } state_t;

   localparam logic [3:0] AVM_BYTEENABLE = 4'hF;

   function automatic int pixels_per_frame(input int h_active, input int v_active);
      return h_active * v_active;
   endfunction

   // Two RGB565 pixels are packed into each 32-bit memory word.
   function automatic int words_per_frame(input int h_active, input int v_active);
      return (h_active * v_active) / 2;
   endfunction

   localparam int DEFAULT_H_ACTIVE = 640;
   localparam int DEFAULT_V_ACTIVE = 480;
   localparam int DEFAULT_WORDS    = words_per_frame(DEFAULT_H_ACTIVE, DEFAULT_V_ACTIVE);

endpackage

// File: rtl/vga_capture_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO succeeds only when a pop
// happens in the same cycle.
module vga_capture_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/vga_capture.sv
// Captures one armed RGB565 frame into memory through an Avalon-MM write master.
// Optional frame_count/word_count outputs are enabled by VGA_CAPTURE_FRAME_CNT_EN.
module vga_capture
   import vga_capture_pkg::*;
#(
   parameter int H_ACTIVE   = DEFAULT_H_ACTIVE,
   parameter int V_ACTIVE   = DEFAULT_V_ACTIVE,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 32
) (
   input  logic              clock_clk,
   input  logic              clock_sreset_reset_n,
   input  logic [15:0]       vga_rgb,
   input  logic              vga_valid,
   input  logic              vga_vsync,
   input  logic              vga_hsync,
   input  logic              arm,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest
`ifdef VGA_CAPTURE_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_count,
   output logic [ADDR_W-1:0] word_count
`endif
);

   localparam int TOTAL_PIX = pixels_per_frame(H_ACTIVE, V_ACTIVE);
   localparam int WORDS     = words_per_frame(H_ACTIVE, V_ACTIVE);
   localparam int PIX_W     = $clog2(TOTAL_PIX) + 1;
   localparam int WORD_W    = $clog2(WORDS) + 1;
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TOTAL_PIX - 1);

   state_t            state;
   state_t            next_state;
   logic [15:0]       rgb_q;
   logic              valid_q;
   logic              vsync_q;
   logic              vsync_d;
   logic              vs_start;
   logic [15:0]       pack;
   logic [PIX_W-1:0]  pix_cnt;
   logic              push_req;
   logic [31:0]       push_data;
   logic [ADDR_W-1:0] base_q;
   logic [WORD_W-1:0] word_cnt;
   logic [31:0]       fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              overflow;
   logic              arm_accept;
   logic              take_pixel;
   logic              set_error;
   logic              drain_done;
   logic              unused_inputs;

   // hsync carries no information the capture needs, and the frame buffer is word aligned.
   assign unused_inputs = &{1'b0, vga_hsync, base_addr[1:0]};

   assign vs_start       = vsync_d && !vsync_q;
   assign fifo_pop       = avm_write && !avm_waitrequest;
   assign overflow       = push_req && fifo_full && !fifo_pop;
   assign busy           = (state != IDLE);
   assign avm_write      = !fifo_empty;
   assign avm_writedata  = fifo_empty ? 32'h0 : fifo_head;
   assign avm_byteenable = AVM_BYTEENABLE;
   assign avm_address    = base_q + (ADDR_W'(word_cnt) << 2);

   always_ff @(posedge clock_clk or negedge clock_sreset_reset_n) begin
      if (!clock_sreset_reset_n) begin
         rgb_q   <= '0;
         valid_q <= 1'b0;
         vsync_q <= 1'b1;
         vsync_d <= 1'b1;
      end else begin
         rgb_q   <= vga_rgb;
         valid_q <= vga_valid;
         vsync_q <= vga_vsync;
         vsync_d <= vsync_q;
      end
   end

   always_comb begin
      next_state = state;
      arm_accept = 1'b0;
      take_pixel = 1'b0;
      set_error  = 1'b0;
      drain_done = 1'b0;
      case (state)
         IDLE: begin
            if (arm) begin
               arm_accept = 1'b1;
               next_state = WAIT_VS;
            end
         end
         WAIT_VS: begin
            if (vs_start) next_state = CAPTURE;
         end
         CAPTURE: begin
            if (vs_start) begin
               set_error  = 1'b1;
               next_state = DRAIN;
            end else if (valid_q) begin
               take_pixel = 1'b1;
               if (pix_cnt == LAST_PIX) next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty && !push_req) begin
               drain_done = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (overflow) begin
         set_error = 1'b1;
         if (state == CAPTURE) next_state = DRAIN;
      end
   end

   // The odd pixel of each pair is combined with the held even pixel one cycle later.
   always_ff @(posedge clock_clk or negedge clock_sreset_reset_n) begin
      if (!clock_sreset_reset_n) begin
         state     <= IDLE;
         done      <= 1'b0;
         error     <= 1'b0;
         pix_cnt   <= '0;
         pack      <= '0;
         push_req  <= 1'b0;
         push_data <= '0;
         base_q    <= '0;
         word_cnt  <= '0;
      end else begin
         state    <= next_state;
         done     <= drain_done;
         push_req <= take_pixel && pix_cnt[0];
         if (arm_accept)     error <= 1'b0;
         else if (set_error) error <= 1'b1;
         if (arm_accept)      pix_cnt <= '0;
         else if (take_pixel) pix_cnt <= pix_cnt + PIX_W'(1);
         if (take_pixel && !pix_cnt[0]) pack <= rgb_q;
         if (take_pixel && pix_cnt[0])  push_data <= {rgb_q, pack};
         if (arm_accept) base_q <= {base_addr[ADDR_W-1:2], 2'b00};
         if (arm_accept)    word_cnt <= '0;
         else if (fifo_pop) word_cnt <= word_cnt + WORD_W'(1);
      end
   end

`ifdef VGA_CAPTURE_FRAME_CNT_EN
   assign word_count = ADDR_W'(word_cnt);

   always_ff @(posedge clock_clk or negedge clock_sreset_reset_n) begin
      if (!clock_sreset_reset_n) begin
         frame_count <= '0;
      end else if (drain_done && !error) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

   vga_capture_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock_clk),
      .rst_n     (clock_sreset_reset_n),
      .push      (push_req),
      .push_data (push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_vga_capture.sv
// Randomized self-checking bench for vga_capture: an 8x2 frame on a 16-deep instance
// and on a 2-deep instance used to provoke overflow.
module tb_vga_capture;

   localparam int H_ACT = 8;
   localparam int V_ACT = 2;
   localparam int NPIX  = H_ACT * V_ACT;
   localparam int NWORD = NPIX / 2;

   logic        clock_clk = 1'b0;
   logic        rst_n;
   logic [15:0] vga_rgb;
   logic        vga_valid;
   logic        vga_vsync;
   logic        vga_hsync;
   logic        arm_a;
   logic        arm_b;
   logic [31:0] base_addr;
   logic        wr_a;
   logic        wr_b;

   logic        busy_a, done_a, error_a, write_a;
   logic [31:0] addr_a, wdata_a;
   logic [3:0]  be_a;
   logic        busy_b, done_b, error_b, write_b;
   logic [31:0] addr_b, wdata_b;
   logic [3:0]  be_b;
`ifdef VGA_CAPTURE_FRAME_CNT_EN
   logic [15:0] frame_count_a, frame_count_b;
   logic [31:0] word_count_a, word_count_b;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [63:0] acc_a[$];
   logic [63:0] acc_b[$];
   int          done_cnt_a = 0;
   int          done_cnt_b = 0;
   logic [15:0] pix[$];
   bit          rand_wr = 1'b0;
   int          clean_caps = 0;

   always #5 clock_clk = ~clock_clk;

   vga_capture #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .FIFO_DEPTH(16), .ADDR_W(32)) dut_a (
      .clock_clk(clock_clk), .clock_sreset_reset_n(rst_n),
      .vga_rgb(vga_rgb), .vga_valid(vga_valid), .vga_vsync(vga_vsync), .vga_hsync(vga_hsync),
      .arm(arm_a), .base_addr(base_addr),
      .busy(busy_a), .done(done_a), .error(error_a),
      .avm_address(addr_a), .avm_write(write_a), .avm_writedata(wdata_a),
      .avm_byteenable(be_a), .avm_waitrequest(wr_a)
`ifdef VGA_CAPTURE_FRAME_CNT_EN
      , .frame_count(frame_count_a), .word_count(word_count_a)
`endif
   );

   vga_capture #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .FIFO_DEPTH(2), .ADDR_W(32)) dut_b (
      .clock_clk(clock_clk), .clock_sreset_reset_n(rst_n),
      .vga_rgb(vga_rgb), .vga_valid(vga_valid), .vga_vsync(vga_vsync), .vga_hsync(vga_hsync),
      .arm(arm_b), .base_addr(base_addr),
      .busy(busy_b), .done(done_b), .error(error_b),
      .avm_address(addr_b), .avm_write(write_b), .avm_writedata(wdata_b),
      .avm_byteenable(be_b), .avm_waitrequest(wr_b)
`ifdef VGA_CAPTURE_FRAME_CNT_EN
      , .frame_count(frame_count_b), .word_count(word_count_b)
`endif
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock_clk);
         #1;
      end
   endtask

   // Records accepted writes, counts done pulses and checks the bus holds still while stalled.
   logic        stall_a = 1'b0, stall_b = 1'b0;
   logic [63:0] held_a, held_b;
   always @(negedge clock_clk) begin
      if (!rst_n) begin
         stall_a = 1'b0;
         stall_b = 1'b0;
      end else begin
         if (stall_a) begin
            checkOutput("hold_a", {addr_a, wdata_a}, held_a);
            checkOutput("hold_wr_a", 64'(write_a), 64'd1);
         end
         if (stall_b) begin
            checkOutput("hold_b", {addr_b, wdata_b}, held_b);
            checkOutput("hold_wr_b", 64'(write_b), 64'd1);
         end
         if (write_a && !wr_a) acc_a.push_back({addr_a, wdata_a});
         if (write_b && !wr_b) acc_b.push_back({addr_b, wdata_b});
         if (done_a) begin
            done_cnt_a++;
            checkOutput("done_busy_a", 64'(busy_a), 64'd0);
         end
         if (done_b) begin
            done_cnt_b++;
            checkOutput("done_busy_b", 64'(busy_b), 64'd0);
         end
         stall_a = write_a && wr_a;
         stall_b = write_b && wr_b;
         held_a  = {addr_a, wdata_a};
         held_b  = {addr_b, wdata_b};
      end
   end

   // Random slave stalls for instance A when enabled.
   initial begin
      wr_a = 1'b0;
      forever begin
         @(posedge clock_clk);
         #1;
         wr_a = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic armA(input logic [31:0] base);
      acc_a.delete();
      done_cnt_a = 0;
      base_addr  = base;
      arm_a      = 1'b1;
      tick();
      arm_a = 1'b0;
      checkOutput("arm_busy", 64'(busy_a), 64'd1);
      checkOutput("arm_err_clear", 64'(error_a), 64'd0);
   endtask

   // Drives one vsync pulse then npix valid pixels; arm_at pulses arm alongside that pixel.
   task automatic applyStimulus(input int npix, input bit rand_vals, input bit gaps,
                                input bit short_end, input int arm_at);
      logic [15:0] val;
      pix.delete();
      vga_vsync = 1'b0;
      tick(2);
      vga_vsync = 1'b1;
      tick(2);
      for (int i = 0; i < npix; i++) begin
         if (gaps) tick(int'($urandom_range(0, 2)));
         val = rand_vals ? 16'($urandom) : 16'(i);
         pix.push_back(val);
         vga_rgb   = val;
         vga_valid = 1'b1;
         vga_hsync = ((i % H_ACT) == H_ACT - 1) ? 1'b0 : 1'b1;
         if (i == arm_at) begin
            arm_a     = 1'b1;
            base_addr = 32'hDEAD_BEE0;
         end
         tick();
         vga_valid = 1'b0;
         vga_hsync = 1'b1;
         arm_a     = 1'b0;
      end
      if (short_end) begin
         vga_vsync = 1'b0;
         tick(2);
         vga_vsync = 1'b1;
      end
      tick();
   endtask

   // Reference: word i is the pixel pair {pix[2i+1], pix[2i]} at base + 4*i.
   task automatic expectCapture(input string tag, input logic [31:0] base, input int nwords,
                                input bit exp_err);
      logic [63:0] exp;
      logic [63:0] got;
      for (int c = 0; c < 3000 && done_cnt_a == 0; c++) tick();
      tick(3);
      checkOutput({tag, "_done"}, 64'(done_cnt_a), 64'd1);
      checkOutput({tag, "_nwords"}, 64'(acc_a.size()), 64'(nwords));
      for (int i = 0; i < nwords; i++) begin
         exp = {base + 32'(4 * i), pix[2*i+1], pix[2*i]};
         got = (i < acc_a.size()) ? acc_a[i] : 64'hFFFF_FFFF_FFFF_FFFF;
         checkOutput({tag, "_word"}, got, exp);
      end
      checkOutput({tag, "_error"}, 64'(error_a), 64'(exp_err));
      checkOutput({tag, "_idle"}, 64'(busy_a), 64'd0);
      if (!exp_err) clean_caps++;
   endtask

   initial begin
      logic [31:0] base;
      logic [63:0] exp;
      rst_n     = 1'b0;
      vga_rgb   = '0;
      vga_valid = 1'b0;
      vga_vsync = 1'b1;
      vga_hsync = 1'b1;
      arm_a     = 1'b0;
      arm_b     = 1'b0;
      base_addr = '0;
      wr_b      = 1'b0;
      tick(3);
      checkOutput("reset_flags", {60'd0, busy_a, done_a, error_a, write_a}, 64'd0);
      checkOutput("reset_bus", {addr_a, wdata_a}, 64'd0);
      checkOutput("reset_b", {addr_b, wdata_b} | 64'({busy_b, done_b, error_b, write_b}), 64'd0);
      checkOutput("byteenable", 64'(be_a), 64'hF);
      rst_n = 1'b1;
      tick(2);

      // Basic frame with counting pixel values and no stalls.
      armA(32'h1000);
      applyStimulus(NPIX, 1'b0, 1'b0, 1'b0, -1);
      expectCapture("basic", 32'h1000, NWORD, 1'b0);
      checkOutput("basic_first", acc_a.size() > 0 ? acc_a[0] : 64'd0, {32'h1000, 32'h0001_0000});
      checkOutput("basic_last", acc_a.size() > 7 ? acc_a[7] : 64'd0, {32'h101C, 32'h000F_000E});

      // Random data, random pixel gaps and random backpressure.
      rand_wr = 1'b1;
      base = $urandom & 32'hFFFF_FFFC;
      armA(base);
      applyStimulus(NPIX, 1'b1, 1'b1, 1'b0, -1);
      expectCapture("backpressure", base, NWORD, 1'b0);
      rand_wr = 1'b0;

      // Short frame: five pixels then a new vsync; the unpaired fifth pixel is dropped.
      base = $urandom & 32'hFFFF_FFFC;
      armA(base);
      applyStimulus(5, 1'b1, 1'b1, 1'b1, -1);
      expectCapture("short", base, 2, 1'b1);

      // Overflow on the 2-deep instance with the slave stalled throughout the frame.
      acc_b.delete();
      done_cnt_b = 0;
      base_addr  = 32'h2000;
      wr_b       = 1'b1;
      arm_b      = 1'b1;
      tick();
      arm_b = 1'b0;
      applyStimulus(NPIX, 1'b1, 1'b0, 1'b0, -1);
      tick(5);
      checkOutput("ovf_error", 64'(error_b), 64'd1);
      checkOutput("ovf_stalled", 64'(acc_b.size()), 64'd0);
      checkOutput("ovf_nodone", 64'(done_cnt_b), 64'd0);
      wr_b = 1'b0;
      for (int c = 0; c < 3000 && done_cnt_b == 0; c++) tick();
      tick(3);
      checkOutput("ovf_done", 64'(done_cnt_b), 64'd1);
      checkOutput("ovf_nwords", 64'(acc_b.size()), 64'd2);
      for (int i = 0; i < 2; i++) begin
         exp = {32'h2000 + 32'(4 * i), pix[2*i+1], pix[2*i]};
         checkOutput("ovf_word", (i < acc_b.size()) ? acc_b[i] : 64'd0, exp);
      end
      checkOutput("ovf_error_sticky", 64'(error_b), 64'd1);

      // An arm during capture is ignored; the original base address is kept.
      armA(32'h3000);
      applyStimulus(NPIX, 1'b1, 1'b1, 1'b0, 6);
      expectCapture("armignore", 32'h3000, NWORD, 1'b0);

      // Reset in the middle of a capture abandons it without a done pulse.
      armA(32'h4000);
      applyStimulus(6, 1'b1, 1'b0, 1'b0, -1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_flags", {60'd0, busy_a, done_a, error_a, write_a}, 64'd0);
      checkOutput("midrst_bus", {addr_a, wdata_a}, 64'd0);
      tick(3);
      checkOutput("midrst_nodone", 64'(done_cnt_a), 64'd0);
      rst_n = 1'b1;
      clean_caps = 0;
      tick(2);

      // Three clean captures after the reset.
      for (int k = 0; k < 3; k++) begin
         rand_wr = (k == 1);
         base = $urandom & 32'hFFFF_FFFC;
         armA(base);
         applyStimulus(NPIX, 1'b1, 1'b1, 1'b0, -1);
         expectCapture("clean", base, NWORD, 1'b0);
      end
      rand_wr = 1'b0;
      tick(2);

`ifdef VGA_CAPTURE_FRAME_CNT_EN
      checkOutput("frame_count", 64'(frame_count_a), 64'(clean_caps));
      checkOutput("word_count", 64'(word_count_a), 64'(NWORD));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_capture.md
# vga_capture

Video stream capture sink for the pd_block fabric: consumes the same RGB565 pixel stream that pd_block drives out on vga_rgb/vga_valid/vga_vsync/vga_hsync. It captures one armed frame and writes it as packed 32-bit words to memory, normally SDRAM, through an Avalon-MM write master. It is used for frame readback and self-check of the display path and inference overlays.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line; must be even.
- V_ACTIVE, 480, active lines per frame.
- FIFO_DEPTH, 16, words in the internal write FIFO; power of two.
- ADDR_W, 32, Avalon address width.

Ports:
- clock_clk  in  1  single clock; the video stream is synchronous to it.
- clock_sreset_reset_n  in  1  reset; asynchronous, active-low.
- vga_rgb  in  16  RGB565 pixel.
- vga_valid  in  1  pixel qualifier, active-high.
- vga_vsync  in  1  frame sync, active-low.
- vga_hsync  in  1  line sync, active-low; informational only, not used for counting.
- arm  in  1  one-cycle request to capture the next frame.
- base_addr  in  ADDR_W  byte address of the frame buffer; sampled on accepted arm.
- busy  out  1  high from accepted arm until done.
- done  out  1  one-cycle pulse at end of capture.
- error  out  1  sticky; set on overflow or short frame; cleared by the next accepted arm.
- avm_address  out  ADDR_W  write address, word aligned.
- avm_write  out  1  write request.
- avm_writedata  out  32  packed pixel pair.
- avm_byteenable  out  4  always 4'hF.
- avm_waitrequest  in  1  slave stall.

## Operation
- Input stage: vga_rgb, vga_valid and vga_vsync are registered once. A vsync start is the 1→0 edge of the registered vsync.
- State machine states: IDLE, WAIT_VS, CAPTURE, DRAIN.
  - IDLE: arm → WAIT_VS; latch base_addr; clear error, pixel counter and word counter; busy=1.
  - WAIT_VS: vsync start → CAPTURE.
  - CAPTURE: each valid pixel increments the pixel counter.
    - Even-index pixel goes to the pack register [15:0].
    - Odd-index pixel forms {pixel, pack[15:0]} and is pushed to the FIFO.
    - Pixel count reaching H_ACTIVE*V_ACTIVE → DRAIN.
  - DRAIN: FIFO empty and no write outstanding → IDLE with done=1 and busy=0 in the same cycle.
- Short frame: a vsync start in CAPTURE before the count completes sets error and goes to DRAIN. A half-filled pack register is discarded.
- Overflow: a push while the FIFO is full drops the word, sets error and goes to DRAIN. Words already queued are still written.
- Write master:
  - avm_write is high whenever the FIFO is non-empty; writedata is the FIFO head (show-ahead).
  - A write is accepted when avm_write=1 and avm_waitrequest=0. On accept: pop the FIFO and add 4 to avm_address.
  - avm_address = base_addr + 4*accepted_words.
- arm outside IDLE is ignored.
- A push and a pop in the same cycle are both performed, so occupancy is unchanged. A push to a full FIFO with a simultaneous pop is not an overflow.
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0. Reset mid-capture abandons the frame with no done pulse.

## Timing
- Pixel sampled at input register at cycle n. If it is the odd pixel, the FIFO push happens at n+1 and avm_write can first be high at n+2.
- With no waitrequest, sustained throughput is one word per cycle, which exceeds the maximum input rate of half a word per cycle.
- avm_address, avm_writedata and avm_write hold stable while avm_waitrequest=1.
- done occurs at the earliest one cycle after the final accept.
- Total words for a complete frame = H_ACTIVE*V_ACTIVE/2; the counter is sized to $clog2 of that value plus 1.

## Configuration
- VGA_CAPTURE_FRAME_CNT_EN defined:
  - Adds output frame_count[15:0], incremented on each done pulse without error and wrapping at 16'hFFFF→0.
  - Adds output word_count[ADDR_W-1:0], the number of accepted words in the current or last capture.
  - Both are reset to 0.
- Macro undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- vga_capture_pkg holds:
  - the state enum (IDLE, WAIT_VS, CAPTURE, DRAIN);
  - the localparams for words-per-frame computation;
  - the byteenable constant 4'hF.
- One sub-module, vga_capture_fifo: a synchronous show-ahead FIFO with parameters WIDTH=32 and DEPTH=FIFO_DEPTH. It provides full, empty and a simultaneous push/pop rule.

## Test plan
- Basic frame: H_ACTIVE=8, V_ACTIVE=2, base_addr=32'h1000, pixel values 16'h0000..16'h000F, no waitrequest → 8 writes to 0x1000..0x101C, the first word 32'h0001_0000 and the last 32'h000F_000E; then one done pulse, error=0.
- Backpressure: same frame with waitrequest high on a random 50% of cycles and FIFO_DEPTH=16 → same 8 words in the same order, address and data held during stalls, error=0.
- Overflow: FIFO_DEPTH=2 with waitrequest held high through the frame, then released → error=1 and exactly 2 words written; done still pulses after they drain.
- Short frame: vsync start after 5 valid pixels → 2 words written, the fifth pixel discarded; error=1, done pulses.
- Arm handling: arm pulsed during CAPTURE → ignored. Reset asserted mid-CAPTURE → all outputs 0 immediately, no done pulse, and the next arm captures normally.
- Configuration: with VGA_CAPTURE_FRAME_CNT_EN defined, three clean captures → frame_count=3 and word_count=8.
